// File: rtl/reg_file.sv
// 32 x 64-bit register file with two combinational read ports and one write port.
// X31 is hard-wired to zero; all other registers clear asynchronously on rst_n.

// One-hot write-enable decoder. X31 has no storage, so only X0..X30 get an enable;
// an index of 31 simply produces no enable.
module regDecoder #(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                  writeEnable,
  input  logic [IDX_W-1:0]      writeIndex,
  output logic [NUM_REGS-2:0]   regEnable
);

  // Decode the write index and gate it with the write enable.
  always_comb begin
    regEnable = '0;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      if (writeEnable && (writeIndex == IDX_W'(i))) begin
        regEnable[i] = 1'b1;
      end
    end
  end

endmodule

// One storage register with load enable and asynchronous clear.
module regCell #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic [DATA_WIDTH-1:0] dataOut
);

  // Load on enable; clear immediately when reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataOut <= '0;
    end else if (enable) begin
      dataOut <= dataIn;
    end
  end

endmodule

// One-bit N:1 selector; one instance per output bit per read port.
module regMux #(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0] bitsIn,
  input  logic [IDX_W-1:0]    select,
  output logic                bitOut
);

  // Pick the bit of the addressed register.
  always_comb begin
    bitOut = bitsIn[select];
  end

endmodule

module reg_file #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWrite,
  input  logic [4:0]            WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [4:0]            ReadRegister1,
  input  logic [4:0]            ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  localparam int IDX_W = 5;

  logic [NUM_REGS-2:0]   regEnable;
  logic [DATA_WIDTH-1:0] regQ [NUM_REGS];
  // Bit-sliced view: column b holds bit b of every register, feeding the per-bit muxes.
  logic [NUM_REGS-1:0]   bitColumn [DATA_WIDTH];

  regDecoder #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) uDecoder (
    .writeEnable (RegWrite),
    .writeIndex  (WriteRegister),
    .regEnable   (regEnable)
  );

  for (genvar r = 0; r < NUM_REGS - 1; r++) begin : gCell
    regCell #(
      .DATA_WIDTH (DATA_WIDTH)
    ) uCell (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (regEnable[r]),
      .dataIn  (WriteData),
      .dataOut (regQ[r])
    );
  end

  // The last register is the zero register: constant, no storage.
  always_comb begin
    regQ[NUM_REGS-1] = '0;
  end

  for (genvar b = 0; b < DATA_WIDTH; b++) begin : gBit
    for (genvar r = 0; r < NUM_REGS; r++) begin : gCol
      assign bitColumn[b][r] = regQ[r][b];
    end

    regMux #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
    ) uMux1 (
      .bitsIn (bitColumn[b]),
      .select (ReadRegister1),
      .bitOut (ReadData1[b])
    );

    regMux #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
    ) uMux2 (
      .bitsIn (bitColumn[b]),
      .select (ReadRegister2),
      .bitOut (ReadData2[b])
    );
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, zero register, fill, gating, read-during-write,
// dual port and asynchronous reset.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  int assertCount = 0;
  int failCount   = 0;

  localparam logic [63:0] FILL_STEP = 64'h0000010204080001;

  reg_file #(
    .DATA_WIDTH (64),
    .NUM_REGS   (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Write one register: inputs change on the falling edge, write lands on the next rising edge.
  task automatic doWrite(input logic [4:0] idx, input logic [63:0] data);
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = idx;
    WriteData     = data;
    @(negedge clk);
    RegWrite      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    RegWrite = 1'b0;
    WriteRegister = '0;
    WriteData = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 32; i += 7) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(31 - i);
      #1;
      assertCount++;
      if (ReadData1 !== 64'h0 || ReadData2 !== 64'h0) begin
        failCount++;
        $display("FAIL reset_read idx=%0d rd1=%h rd2=%h expected 0", i, ReadData1, ReadData2);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_reg();
    doWrite(5'd31, 64'hA0);
    ReadRegister1 = 5'd31;
    #1;
    assertCount++;
    if (ReadData1 !== 64'h0) begin
      failCount++;
      $display("FAIL zero_reg rd1=%h expected 0", ReadData1);
    end
  endtask

  task automatic test_fill();
    logic [63:0] expVal;
    for (int i = 0; i < 31; i++) begin
      doWrite(5'(i), 64'(i) * FILL_STEP);
    end
    for (int i = 0; i < 32; i++) begin
      expVal = (i == 31) ? 64'h0 : 64'(i) * FILL_STEP;
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(31 - i);
      #1;
      assertCount++;
      if (ReadData1 !== expVal) begin
        failCount++;
        $display("FAIL fill_port1 idx=%0d got=%h expected=%h", i, ReadData1, expVal);
      end
      expVal = (i == 0) ? 64'h0 : 64'(31 - i) * FILL_STEP;
      assertCount++;
      if (ReadData2 !== expVal) begin
        failCount++;
        $display("FAIL fill_port2 idx=%0d got=%h expected=%h", 31 - i, ReadData2, expVal);
      end
    end
  endtask

  task automatic test_write_gating();
    @(negedge clk);
    RegWrite      = 1'b0;
    WriteRegister = 5'd5;
    WriteData     = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (4) @(posedge clk);
    #1;
    ReadRegister1 = 5'd5;
    ReadRegister2 = 5'd6;
    #1;
    assertCount++;
    if (ReadData1 !== 64'h0000050A14280005) begin
      failCount++;
      $display("FAIL write_gating X5 got=%h expected=%h", ReadData1, 64'h0000050A14280005);
    end
    assertCount++;
    if (ReadData2 !== 64'h0000060C18300006) begin
      failCount++;
      $display("FAIL write_gating X6 got=%h expected=%h", ReadData2, 64'h0000060C18300006);
    end
  endtask

  task automatic test_read_during_write();
    doWrite(5'd3, 64'h11);
    @(negedge clk);
    ReadRegister1 = 5'd3;
    RegWrite      = 1'b1;
    WriteRegister = 5'd3;
    WriteData     = 64'h22;
    #1;
    assertCount++;
    if (ReadData1 !== 64'h11) begin
      failCount++;
      $display("FAIL rdw_before got=%h expected=%h", ReadData1, 64'h11);
    end
    @(posedge clk);
    #1;
    assertCount++;
    if (ReadData1 !== 64'h22) begin
      failCount++;
      $display("FAIL rdw_after got=%h expected=%h", ReadData1, 64'h22);
    end
    @(negedge clk);
    RegWrite = 1'b0;
  endtask

  task automatic test_dual_port();
    ReadRegister1 = 5'd7;
    ReadRegister2 = 5'd7;
    #1;
    assertCount++;
    if (ReadData1 !== 64'h0000070E1C380007 || ReadData2 !== 64'h0000070E1C380007) begin
      failCount++;
      $display("FAIL dual_port rd1=%h rd2=%h expected=%h", ReadData1, ReadData2, 64'h0000070E1C380007);
    end
  endtask

  task automatic test_async_reset();
    // Drop reset between edges and check reads clear without any clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 31; i += 5) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(i + 1);
      #1;
      assertCount++;
      if (ReadData1 !== 64'h0 || ReadData2 !== 64'h0) begin
        failCount++;
        $display("FAIL async_reset_clear idx=%0d rd1=%h rd2=%h expected 0", i, ReadData1, ReadData2);
      end
    end
    doWrite(5'd1, 64'h5A);
    ReadRegister1 = 5'd1;
    #1;
    assertCount++;
    if (ReadData1 !== 64'h0) begin
      failCount++;
      $display("FAIL write_in_reset X1 got=%h expected 0", ReadData1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    doWrite(5'd1, 64'h5A);
    #1;
    assertCount++;
    if (ReadData1 !== 64'h5A) begin
      failCount++;
      $display("FAIL write_after_reset X1 got=%h expected=%h", ReadData1, 64'h5A);
    end
    ReadRegister2 = 5'd2;
    #1;
    assertCount++;
    if (ReadData2 !== 64'h0) begin
      failCount++;
      $display("FAIL reset_discard X2 got=%h expected 0", ReadData2);
    end
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_fill();
    test_write_gating();
    test_read_during_write();
    test_dual_port();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
